uart_rx_fifo: RTL

Receive-side byte buffer between the UART receiver and the UART control/status register block. Accepts each received byte with its per-byte error flags, holds up to DEPTH entries, and presents them first-word-fall-through to the register block. Also generates the fill-level, threshold, overflow and idle-timeout indications that feed the RX status word and `rx_irq`.

---
 rtl/uart_defs_pkg.sv | 17 +
 rtl/uart_fifo_ram.sv | 27 ++
 rtl/uart_rx_fifo.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/uart_defs_pkg.sv
// Shared UART receive-path types: per-byte error flags and the FIFO entry payload.
package uart_defs;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned ERR_W  = 2;

    typedef struct packed {
        logic frame_err;
        logic parity_err;
    } RxErr_t;

    typedef struct packed {
        RxErr_t            err;
        logic [BYTE_W-1:0] data;
    } RxFifoEntry_t;

endpackage

// File: rtl/uart_fifo_ram.sv
// Register-array storage for the RX FIFO: one synchronous write port, one asynchronous read port.
module uart_fifo_ram
    import uart_defs::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  RxFifoEntry_t      wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output RxFifoEntry_t      rdata_o
);

    RxFifoEntry_t mem_q [DEPTH];

    // Storage write; the array carries no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// RX byte FIFO (first-word-fall-through) with fill level, threshold, sticky overflow and idle timeout.
module uart_rx_fifo
    import uart_defs::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned TO_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic [7:0]               wr_d_i,
    input  logic [1:0]               wr_err_i,
    input  logic                     wr_valid_i,
    output logic                     wr_ready_o,
    output logic [7:0]               rd_d_o,
    output logic [1:0]               rd_err_o,
    output logic                     rd_valid_o,
    input  logic                     rd_ready_i,
    output logic [$clog2(DEPTH):0]   level_o,
    input  logic [$clog2(DEPTH):0]   thresh_i,
    output logic                     thresh_o,
    input  logic                     ovf_clr_i,
    output logic                     overflow_o,
    input  logic [TO_W-1:0]          timeout_i,
    output logic                     timeout_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [TO_W-1:0]  cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             ready_q, ready_d;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             ram_we;
    RxFifoEntry_t     wr_entry;
    RxFifoEntry_t     rd_entry;

    assign full  = (level_q == LVL_FULL);
    assign empty = (level_q == '0);
    assign push  = wr_valid_i & ready_q;
    assign pop   = rd_ready_i & ~empty;

    assign wr_entry.err.frame_err  = wr_err_i[1];
    assign wr_entry.err.parity_err = wr_err_i[0];
    assign wr_entry.data           = wr_d_i;

    // A flush swallows any same-cycle push, so it must not reach the array either.
    assign ram_we = push & ~flush_i;

    uart_fifo_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry)
    );

    // Next-state for pointers, level, idle counter, overflow flag and write-ready.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase

            // Idle counter restarts on any traffic or while empty, else saturates at the timeout.
            if (push || pop || empty) begin
                cnt_d = '0;
            end else if (cnt_q >= timeout_i) begin
                cnt_d = timeout_i;
            end else begin
                cnt_d = cnt_q + TO_W'(1);
            end
        end

        // Dropped byte sets the sticky flag; set beats clear.
        if (wr_valid_i && full && !flush_i) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end

        ready_d = (level_d != LVL_FULL);
    end

    // State register with synchronous reset; write-ready stays low while reset is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            ready_q  <= ready_d;
        end
    end

    assign wr_ready_o = ready_q;
    assign level_o    = level_q;
    assign rd_valid_o = ~empty;
    assign rd_d_o     = empty ? 8'h00 : rd_entry.data;
    assign rd_err_o   = empty ? 2'b00 : {rd_entry.err.frame_err, rd_entry.err.parity_err};
    assign overflow_o = ovf_q;
    assign thresh_o   = (thresh_i != '0) && (level_q >= thresh_i);
    assign timeout_o  = (timeout_i != '0) && !empty && (cnt_q == timeout_i);

endmodule
